// File: rtl/legv8_fetch_unit.sv
// -----------------------------------------------------------------------------
// legv8_fetch_unit
//
// Instruction-fetch stage of the LEGv8 pipeline. Owns the program counter and
// fills the IF/ID pipeline register from a combinational, big-endian,
// byte-addressed instruction memory. It handles hazard stall, IF/ID flush,
// branch redirect and a sticky halt on an illegal fetch address.
//
// Parameters
//   RESET_PC    PC loaded on reset (word-aligned)
//   MEM_BYTES   instruction memory size; a fetch is legal when PC+3 < MEM_BYTES
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               hold PC and IF/ID
//   flush               invalidate IF/ID at the next edge
//   br_taken/br_target  redirect request and its target address
//   PC                  registered fetch address to memory
//   inst                instruction word returned for PC (same cycle)
//   if_id_inst/pc/pc4   captured instruction, its address, address + 4
//   if_id_valid         IF/ID holds a real instruction
//   fault/fault_pc      sticky address fault and the offending PC
//   fetch_count         instructions delivered into IF/ID (wraps)
// -----------------------------------------------------------------------------
module legv8_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic [63:0] PC,
  input  logic [31:0] inst,
  output logic [31:0] if_id_inst,
  output logic [63:0] if_id_pc,
  output logic [63:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fault,
  output logic [63:0] fault_pc,
  output logic [31:0] fetch_count
);

  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FAULT = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] ipc_q, ipc_d;
  logic [63:0] ipc4_q, ipc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [63:0] fault_pc_q, fault_pc_d;
  logic [31:0] cnt_q, cnt_d;

  logic [63:0] pc_plus4_s;
  logic        pc_legal_s;

  // Sequential PC and aligned-range legality check; an aligned PC cannot
  // wrap when 3 is added, so a plain 64-bit compare is exact.
  assign pc_plus4_s = pc_q + 64'd4;
  assign pc_legal_s = (pc_q[1:0] == 2'b00) && ((pc_q + 64'd3) < MEM_LIMIT);

  // Next-state and IF/ID update: priority fault > redirect > stall > flush > fetch
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    ipc_d      = ipc_q;
    ipc4_d     = ipc4_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        valid_d = 1'b0;
      end
      ST_RUN: begin
        if (!pc_legal_s) begin
          state_d    = ST_FAULT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
          valid_d    = 1'b0;
        end else if (br_taken) begin
          // Redirect wins over stall and flush; target is checked next edge.
          pc_d    = br_target;
          valid_d = 1'b0;
        end else if (stall) begin
          // Stall with flush kills the held slot but keeps its data.
          if (flush) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end else if (flush) begin
          pc_d    = pc_plus4_s;
          valid_d = 1'b0;
        end else begin
          inst_d  = inst;
          ipc_d   = pc_q;
          ipc4_d  = pc_plus4_s;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 32'd1;
          pc_d    = pc_plus4_s;
        end
      end
      ST_FAULT: begin
        valid_d = 1'b0;
      end
      default: begin
        // Unreachable encoding: park in the safe terminal state.
        state_d = ST_FAULT;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and pipeline registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      inst_q     <= 32'd0;
      ipc_q      <= 64'd0;
      ipc4_q     <= 64'd0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 64'd0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      ipc_q      <= ipc_d;
      ipc4_q     <= ipc4_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign PC          = pc_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc    = ipc_q;
  assign if_id_pc4   = ipc4_q;
  assign if_id_valid = valid_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_legv8_fetch_unit
//
// Directed stimulus drives stall/flush/branch/reset sequences and pushes the
// hand-computed IF/ID contents it expects into a queue. A monitor pops one
// entry each time the DUT delivers a new instruction. Memory word at byte
// address a is 32'hA000_0000 + a, stored big-endian.
// -----------------------------------------------------------------------------
module tb_legv8_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        br_taken;
  logic [63:0] br_target;
  logic [63:0] PC;
  logic [31:0] inst;
  logic [31:0] if_id_inst;
  logic [63:0] if_id_pc;
  logic [63:0] if_id_pc4;
  logic        if_id_valid;
  logic        fault;
  logic [63:0] fault_pc;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] pc4;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem [0:255];
  int          checks;
  int          errors;
  logic [31:0] last_cnt;

  legv8_fetch_unit #(.RESET_PC(64'h0), .MEM_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .br_taken(br_taken), .br_target(br_target), .PC(PC), .inst(inst),
    .if_id_inst(if_id_inst), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .fault(fault), .fault_pc(fault_pc),
    .fetch_count(fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Big-endian combinational instruction memory
  always_comb begin
    inst = 32'hDEAD_BEEF;
    if (PC < 64'd253) begin
      inst = {mem[PC[7:0]], mem[PC[7:0] + 8'd1], mem[PC[7:0] + 8'd2], mem[PC[7:0] + 8'd3]};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [63:0] p, input logic [31:0] c);
    exp_t e;
    e.inst = i; e.pc = p; e.pc4 = p + 64'd4; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every new delivery (fetch_count moved while valid) is scored
  always @(negedge clk) begin
    if (!rst_n) begin
      last_cnt = 32'd0;
    end else if (if_id_valid && fetch_count != last_cnt) begin
      last_cnt = fetch_count;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_capture: got pc %0h, expected none", if_id_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_inst", {32'd0, if_id_inst}, {32'd0, e.inst});
        chk("sb_pc", if_id_pc, e.pc);
        chk("sb_pc4", if_id_pc4, e.pc4);
        chk("sb_cnt", {32'd0, fetch_count}, {32'd0, e.cnt});
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"}, PC, 64'h0);
    chk({tag, "_inst"}, {32'd0, if_id_inst}, 64'd0);
    chk({tag, "_ipc"}, if_id_pc, 64'd0);
    chk({tag, "_ipc4"}, if_id_pc4, 64'd0);
    chk({tag, "_valid"}, {63'd0, if_id_valid}, 64'd0);
    chk({tag, "_fault"}, {63'd0, fault}, 64'd0);
    chk({tag, "_fault_pc"}, fault_pc, 64'd0);
    chk({tag, "_count"}, {32'd0, fetch_count}, 64'd0);
  endtask

  initial begin
    logic [31:0] w;
    checks    = 0;
    errors    = 0;
    last_cnt  = 32'd0;
    for (int a = 0; a < 256; a += 4) begin
      w = 32'hA000_0000 + 32'(a);
      mem[a]     = w[31:24];
      mem[a + 1] = w[23:16];
      mem[a + 2] = w[15:8];
      mem[a + 3] = w[7:0];
    end
    rst_n     = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    br_taken  = 1'b0;
    br_target = 64'd0;

    #3;
    chk_reset_outputs("rst");
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Boot, then A/B
    push(32'hA000_0000, 64'h0, 32'd1);
    push(32'hA000_0004, 64'h4, 32'd2);
    step();
    chk("boot_valid", {63'd0, if_id_valid}, 64'd0);
    chk("boot_pc", PC, 64'h0);
    step();
    chk("capA_pc", PC, 64'h4);
    step();
    chk("capB_pc", PC, 64'h8);

    // Stall for 3 cycles holding B
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", PC, 64'h8);
      chk("stall_valid", {63'd0, if_id_valid}, 64'd1);
      chk("stall_ipc", if_id_pc, 64'h4);
      chk("stall_count", {32'd0, fetch_count}, 64'd2);
    end
    stall = 1'b0;
    push(32'hA000_0008, 64'h8, 32'd3);
    step();
    chk("capC_pc", PC, 64'hC);

    // Branch overrides stall
    stall = 1'b1; br_taken = 1'b1; br_target = 64'h40;
    step();
    chk("br_pc", PC, 64'h40);
    chk("br_valid", {63'd0, if_id_valid}, 64'd0);
    stall = 1'b0; br_taken = 1'b0;
    push(32'hA000_0040, 64'h40, 32'd4);
    step();
    chk("br_tgt_pc", PC, 64'h44);

    // Flush alone at PC 0x10
    br_taken = 1'b1; br_target = 64'h10;
    step();
    br_taken = 1'b0; flush = 1'b1;
    step();
    chk("flush_pc", PC, 64'h14);
    chk("flush_valid", {63'd0, if_id_valid}, 64'd0);
    chk("flush_count", {32'd0, fetch_count}, 64'd4);
    flush = 1'b0;
    push(32'hA000_0014, 64'h14, 32'd5);
    step();
    chk("post_flush_pc", PC, 64'h18);

    // Stall together with flush: slot killed, data and PC held
    stall = 1'b1; flush = 1'b1;
    step();
    chk("sf_pc", PC, 64'h18);
    chk("sf_valid", {63'd0, if_id_valid}, 64'd0);
    chk("sf_ipc", if_id_pc, 64'h14);
    stall = 1'b0; flush = 1'b0;
    push(32'hA000_0018, 64'h18, 32'd6);
    step();

    // Misaligned branch target faults on the following edge
    br_taken = 1'b1; br_target = 64'h42;
    step();
    chk("mis_pc", PC, 64'h42);
    chk("mis_fault_early", {63'd0, fault}, 64'd0);
    br_taken = 1'b0;
    step();
    chk("mis_fault", {63'd0, fault}, 64'd1);
    chk("mis_fault_pc", fault_pc, 64'h42);
    chk("mis_valid", {63'd0, if_id_valid}, 64'd0);
    br_taken = 1'b1; br_target = 64'h0;
    step();
    chk("frz_pc", PC, 64'h42);
    chk("frz_fault", {63'd0, fault}, 64'd1);
    chk("frz_count", {32'd0, fetch_count}, 64'd6);
    chk("frz_ipc", if_id_pc, 64'h18);
    br_taken = 1'b0;

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(negedge clk); #1;
    rst_n = 1'b1;
    push(32'hA000_0000, 64'h0, 32'd1);
    step();
    chk("reboot_valid", {63'd0, if_id_valid}, 64'd0);
    step();
    chk("recapA_pc", PC, 64'h4);

    // Run off the end of memory from 0xF8
    br_taken = 1'b1; br_target = 64'hF8;
    step();
    br_taken = 1'b0;
    push(32'hA000_00F8, 64'hF8, 32'd2);
    push(32'hA000_00FC, 64'hFC, 32'd3);
    step();
    step();
    chk("end_pc", PC, 64'h100);
    step();
    chk("end_fault", {63'd0, fault}, 64'd1);
    chk("end_fault_pc", fault_pc, 64'h100);
    chk("end_pc_frozen", PC, 64'h100);
    chk("end_valid", {63'd0, if_id_valid}, 64'd0);
    chk("end_count", {32'd0, fetch_count}, 64'd3);

    @(negedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/legv8_fetch_unit.md
# legv8_fetch_unit

Instruction-fetch stage of the LEGv8 CPU. Owns the program counter and drives it as `PC` to the byte-addressed, big-endian instruction memory. The memory returns the 32-bit `inst` combinationally in the same cycle. The unit captures that word, with its PC and PC+4, into the IF/ID pipeline register consumed by decode, and it handles stall, flush, branch redirect and address-fault halt.

## Interface
Parameters:
- `RESET_PC`, 64'h0, PC value loaded on reset; must be word-aligned.
- `MEM_BYTES`, 256, instruction-memory size in bytes; legal fetch requires `PC + 3 < MEM_BYTES`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard stall from decode; hold PC and IF/ID.
- `flush`  in  1  invalidate the IF/ID contents at the next edge.
- `br_taken`  in  1  redirect request from the branch-resolution stage.
- `br_target`  in  64  redirect address, sampled when `br_taken`=1.
- `PC`  out  64  fetch address to instruction memory (registered).
- `inst`  in  32  instruction word from memory for current `PC`.
- `if_id_inst`  out  32  latched instruction.
- `if_id_pc`  out  64  address of `if_id_inst`.
- `if_id_pc4`  out  64  `if_id_pc + 4`, modulo 2^64.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `fault`  out  1  sticky fetch-address fault.
- `fault_pc`  out  64  PC that caused the fault.
- `fetch_count`  out  32  number of instructions delivered into IF/ID; wraps at 2^32.

## Operation
- Reset (`rst_n`=0, asynchronous): `PC`=`RESET_PC`. All `if_id_*` are 0, `if_id_valid`=0, `fault`=0, `fault_pc`=0, `fetch_count`=0. State is BOOT.
- States:
  - BOOT: one cycle. No capture and `if_id_valid` stays 0. Goes to RUN unconditionally.
  - RUN: normal operation.
  - FAULT: terminal; only `rst_n` exits.
- The current `PC` is legal when `PC[1:0]`=0 and `PC + 3 < MEM_BYTES`.
- RUN, per edge, first matching rule wins:
  - PC illegal: go to FAULT, `fault`<=1, `fault_pc`<=`PC`, `if_id_valid`<=0. PC is held.
  - `br_taken`: `PC`<=`br_target`, `if_id_valid`<=0. This overrides `stall` and `flush`.
  - `stall`: PC held. If `flush`, `if_id_valid`<=0 and the rest of IF/ID is held; otherwise all of IF/ID is held.
  - `flush`: `PC`<=`PC+4`, `if_id_valid`<=0.
  - Otherwise: capture `inst`, `PC` and `PC+4` into IF/ID, `if_id_valid`<=1, `fetch_count`+=1, `PC`<=`PC+4`.
- FAULT: `PC`, `if_id_*` data and `fetch_count` frozen. `if_id_valid`=0. `stall`, `flush` and `br_taken` are ignored.
- A misaligned or out-of-range `br_target` is loaded without checking; the fault is raised on the next edge when it becomes the current PC.
- PC arithmetic is 64-bit unsigned and wraps modulo 2^64. In practice the wrapped value is caught by the range check.

## Timing
- `PC` changes only on a clock edge or on reset assertion. `inst` must settle within the same cycle.
- Fetch-to-IF/ID latency: 1 cycle. The word at `PC` in cycle n appears on `if_id_*` in cycle n+1.
- Throughput: 1 instruction/cycle in RUN with no stall.
- The first valid IF/ID appears 2 edges after `rst_n` rises (BOOT edge, then the capture edge).
- Redirect penalty: 1 bubble. `if_id_valid`=0 in the cycle after `br_taken`; the target instruction is valid the cycle after that.
- Reset asserted mid-operation clears all outputs immediately, without waiting for a clock edge. Release is synchronous to the next rising edge.

## Test plan
- Reset release, `RESET_PC`=0, memory words A/B/C at 0x0/0x4/0x8: BOOT cycle has valid=0. Next cycles give {inst=A, pc=0, pc4=4}, then {B, 4, 8}, then {C, 8, 0xC}. `fetch_count` reads 1, 2, 3.
- `stall` held for 3 cycles while IF/ID holds B: `PC` stays 0x8, IF/ID stays B with valid=1, `fetch_count` is unchanged. After release, C is captured.
- `br_taken`=1 with `br_target`=0x40 while `stall`=1: `PC`=0x40 next cycle with valid=0. The following cycle gives IF/ID = word at 0x40 with pc=0x40.
- `flush` alone at `PC`=0x10: valid=0 for one cycle, `PC`=0x14. The next capture is the word at 0x14, and `fetch_count` skips the flushed slot.
- Branch to 0x42: next edge `fault`=1, `fault_pc`=0x42, `PC` frozen at 0x42. A later `br_taken` to 0x0 is ignored. Sequential run from 0xF8 with 256 B memory: captures 0xF8 and 0xFC, then faults with `fault_pc`=0x100.
- Assert `rst_n`=0 mid-stream between clock edges: all outputs return to reset values immediately. After release, behaviour matches scenario 1.
